// File: rtl/force_integrator.sv
// force_integrator
//
// Per-node integration stage for one point mass of the soft-body car.
// Spring force contributions are summed into saturating accumulators while
// idle. A step command then runs a semi-implicit Euler update: gravity is
// added to the y sum, velocity is updated from the force sum, position is
// updated from the new velocity, and finally the node is clamped to the
// floor with a damped bounce.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   init_valid/init_x/_y    load position, zero velocity and accumulators
//   force_valid/force_x/_y  one signed force contribution per cycle
//   step_valid              start one integration step (ignored while busy)
//   pos_x/_y, vel_x/_y      node state, fed back to the spring stages
//   busy                    step in progress
//   result_valid            one-cycle pulse when pos/vel have been updated
//   drop_err                sticky flag: a force arrived while busy
module force_integrator #(
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int FORCE_SIZE    = 24,
  parameter int DT_SHIFT      = 4,
  parameter int POS_SHIFT     = 4,
  parameter int GRAVITY       = -16,
  parameter int FLOOR_Y       = 0
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            init_valid,
  input  logic signed [POSITION_SIZE-1:0] init_x,
  input  logic signed [POSITION_SIZE-1:0] init_y,
  input  logic                            force_valid,
  input  logic signed [FORCE_SIZE-1:0]    force_x,
  input  logic signed [FORCE_SIZE-1:0]    force_y,
  input  logic                            step_valid,
  output logic signed [POSITION_SIZE-1:0] pos_x,
  output logic signed [POSITION_SIZE-1:0] pos_y,
  output logic signed [VELOCITY_SIZE-1:0] vel_x,
  output logic signed [VELOCITY_SIZE-1:0] vel_y,
  output logic                            busy,
  output logic                            result_valid,
  output logic                            drop_err
);

  localparam int ACC_SIZE = FORCE_SIZE + 4;
  // Wide enough that no intermediate sum can wrap before it is clamped.
  localparam int WIDE = ACC_SIZE + POSITION_SIZE + VELOCITY_SIZE;

  localparam logic signed [WIDE-1:0] ACC_MAX =
    WIDE'((longint'(1) <<< (ACC_SIZE - 1)) - longint'(1));
  localparam logic signed [WIDE-1:0] ACC_MIN = -ACC_MAX - WIDE'(1);
  localparam logic signed [WIDE-1:0] VEL_MAX =
    WIDE'((longint'(1) <<< (VELOCITY_SIZE - 1)) - longint'(1));
  localparam logic signed [WIDE-1:0] VEL_MIN = -VEL_MAX - WIDE'(1);
  localparam logic signed [WIDE-1:0] POS_MAX =
    WIDE'((longint'(1) <<< (POSITION_SIZE - 1)) - longint'(1));
  localparam logic signed [WIDE-1:0] POS_MIN = -POS_MAX - WIDE'(1);

  typedef enum logic [2:0] {IDLE, GRAV, VEL, POS, FLOOR} state_t;

  state_t                          state_q;
  logic signed [ACC_SIZE-1:0]      accX_q, accY_q;
  logic signed [POSITION_SIZE-1:0] posX_q, posY_q;
  logic signed [VELOCITY_SIZE-1:0] velX_q, velY_q;
  logic                            busy_q, resultValid_q, dropErr_q;

  logic signed [ACC_SIZE-1:0]      accXForce_d, accYForce_d, accYGrav_d;
  logic signed [VELOCITY_SIZE-1:0] velX_d, velY_d, velYBounce_d;
  logic signed [POSITION_SIZE-1:0] posX_d, posY_d;
  logic                            floorHit;

  function automatic logic signed [ACC_SIZE-1:0] satAcc(input logic signed [WIDE-1:0] v);
    logic signed [WIDE-1:0] c;
    c = v;
    if (v > ACC_MAX) c = ACC_MAX;
    else if (v < ACC_MIN) c = ACC_MIN;
    return ACC_SIZE'(c);
  endfunction

  function automatic logic signed [VELOCITY_SIZE-1:0] satVel(input logic signed [WIDE-1:0] v);
    logic signed [WIDE-1:0] c;
    c = v;
    if (v > VEL_MAX) c = VEL_MAX;
    else if (v < VEL_MIN) c = VEL_MIN;
    return VELOCITY_SIZE'(c);
  endfunction

  function automatic logic signed [POSITION_SIZE-1:0] satPos(input logic signed [WIDE-1:0] v);
    logic signed [WIDE-1:0] c;
    c = v;
    if (v > POS_MAX) c = POS_MAX;
    else if (v < POS_MIN) c = POS_MIN;
    return POSITION_SIZE'(c);
  endfunction

  // Candidate values for every arithmetic update. The position update reads
  // the velocity registers, which already hold the new velocity by the time
  // the FSM reaches POS, giving the semi-implicit ordering.
  always_comb begin
    accXForce_d  = satAcc(WIDE'(accX_q) + WIDE'(force_x));
    accYForce_d  = satAcc(WIDE'(accY_q) + WIDE'(force_y));
    accYGrav_d   = satAcc(WIDE'(accY_q) + WIDE'(GRAVITY));
    velX_d       = satVel(WIDE'(velX_q) + WIDE'(accX_q >>> DT_SHIFT));
    velY_d       = satVel(WIDE'(velY_q) + WIDE'(accY_q >>> DT_SHIFT));
    posX_d       = satPos(WIDE'(posX_q) + WIDE'(velX_q >>> POS_SHIFT));
    posY_d       = satPos(WIDE'(posY_q) + WIDE'(velY_q >>> POS_SHIFT));
    velYBounce_d = satVel(-WIDE'(velY_q >>> 1));
    floorHit     = WIDE'(posY_q) < WIDE'(FLOOR_Y);
  end

  // Step sequencer. init_valid overrides whatever the FSM is doing, including
  // a result that would otherwise be reported on this edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      accX_q        <= '0;
      accY_q        <= '0;
      posX_q        <= '0;
      posY_q        <= '0;
      velX_q        <= '0;
      velY_q        <= '0;
      busy_q        <= 1'b0;
      resultValid_q <= 1'b0;
      dropErr_q     <= 1'b0;
    end else if (init_valid) begin
      state_q       <= IDLE;
      accX_q        <= '0;
      accY_q        <= '0;
      posX_q        <= init_x;
      posY_q        <= init_y;
      velX_q        <= '0;
      velY_q        <= '0;
      busy_q        <= 1'b0;
      resultValid_q <= 1'b0;
      dropErr_q     <= 1'b0;
    end else begin
      resultValid_q <= 1'b0;
      if (force_valid && state_q != IDLE) begin
        dropErr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (force_valid) begin
            accX_q <= accXForce_d;
            accY_q <= accYForce_d;
          end
          if (step_valid) begin
            state_q <= GRAV;
            busy_q  <= 1'b1;
          end
        end
        GRAV: begin
          accY_q  <= accYGrav_d;
          state_q <= VEL;
        end
        VEL: begin
          velX_q  <= velX_d;
          velY_q  <= velY_d;
          state_q <= POS;
        end
        POS: begin
          posX_q  <= posX_d;
          posY_q  <= posY_d;
          state_q <= FLOOR;
        end
        FLOOR: begin
          // Below the floor: snap to it and bounce back at half speed.
          if (floorHit) begin
            posY_q <= POSITION_SIZE'(FLOOR_Y);
            velY_q <= velYBounce_d;
          end
          accX_q        <= '0;
          accY_q        <= '0;
          resultValid_q <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pos_x        = posX_q;
  assign pos_y        = posY_q;
  assign vel_x        = velX_q;
  assign vel_y        = velY_q;
  assign busy         = busy_q;
  assign result_valid = resultValid_q;
  assign drop_err     = dropErr_q;

endmodule

// File: tb/tb_force_integrator.sv
// tb_force_integrator
//
// Scoreboard bench for force_integrator. A behavioural model of the node
// predicts each step's result when the step is driven; the expectation is
// queued and compared when result_valid appears. Idle-point state (position,
// velocity, busy, drop_err) is compared against the model directly.
module tb_force_integrator;

  logic               clk_in;
  logic               rst_in;
  logic               init_valid;
  logic signed [15:0] init_x, init_y;
  logic               force_valid;
  logic signed [23:0] force_x, force_y;
  logic               step_valid;
  logic signed [15:0] pos_x, pos_y;
  logic signed [15:0] vel_x, vel_y;
  logic               busy, result_valid, drop_err;

  force_integrator dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .init_valid  (init_valid),
    .init_x      (init_x),
    .init_y      (init_y),
    .force_valid (force_valid),
    .force_x     (force_x),
    .force_y     (force_y),
    .step_valid  (step_valid),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .vel_x       (vel_x),
    .vel_y       (vel_y),
    .busy        (busy),
    .result_valid(result_valid),
    .drop_err    (drop_err)
  );

  typedef struct {
    longint px;
    longint py;
    longint vx;
    longint vy;
    int     stepCycle;
  } exp_t;

  exp_t   sbQueue[$];
  int     errorCount  = 0;
  int     checkCount  = 0;
  int     cycleCount  = 0;
  int     resultCount = 0;

  longint mAccX, mAccY, mPX, mPY, mVX, mVY;
  int     mBusy;
  longint mDropErr;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycleCount <= cycleCount + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic longint satBits(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Drives one cycle of stimulus and advances the model to match the edge
  // that will sample it.
  task automatic applyStimulus(input bit iv, input longint ix, input longint iy,
                               input bit fv, input longint fx, input longint fy,
                               input bit sv);
    bit   busyNow;
    exp_t e;
    @(posedge clk_in);
    #1;
    init_valid  = iv;
    init_x      = 16'(ix);
    init_y      = 16'(iy);
    force_valid = fv;
    force_x     = 24'(fx);
    force_y     = 24'(fy);
    step_valid  = sv;
    busyNow = (mBusy > 0);
    if (busyNow) mBusy--;
    if (iv) begin
      if (busyNow) void'(sbQueue.pop_back());
      mPX = ix; mPY = iy; mVX = 0; mVY = 0;
      mAccX = 0; mAccY = 0; mBusy = 0; mDropErr = 0;
    end else begin
      if (fv) begin
        if (busyNow) mDropErr = 1;
        else begin
          mAccX = satBits(mAccX + fx, 28);
          mAccY = satBits(mAccY + fy, 28);
        end
      end
      if (sv && !busyNow) begin
        mAccY = satBits(mAccY - 16, 28);
        mVX = satBits(mVX + (mAccX >>> 4), 16);
        mVY = satBits(mVY + (mAccY >>> 4), 16);
        mPX = satBits(mPX + (mVX >>> 4), 16);
        mPY = satBits(mPY + (mVY >>> 4), 16);
        if (mPY < 0) begin
          mPY = 0;
          mVY = satBits(-(mVY >>> 1), 16);
        end
        mAccX = 0; mAccY = 0;
        mBusy = 4;
        e.px = mPX; e.py = mPY; e.vx = mVX; e.vy = mVY;
        e.stepCycle = cycleCount;
        sbQueue.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (sbQueue.size() > 0 && n < 20) begin
      idle(1);
      n++;
    end
    if (sbQueue.size() != 0) checkOutput({tag, "_drain_timeout"}, sbQueue.size(), 0);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_posx"}, pos_x, mPX);
    checkOutput({tag, "_posy"}, pos_y, mPY);
    checkOutput({tag, "_velx"}, vel_x, mVX);
    checkOutput({tag, "_vely"}, vel_y, mVY);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_droperr"}, drop_err, mDropErr);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_posx"}, pos_x, 0);
    checkOutput({tag, "_posy"}, pos_y, 0);
    checkOutput({tag, "_velx"}, vel_x, 0);
    checkOutput({tag, "_vely"}, vel_y, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rv"}, result_valid, 0);
    checkOutput({tag, "_droperr"}, drop_err, 0);
  endtask

  task automatic applyReset();
    #1;
    rst_in      = 1'b1;
    init_valid  = 1'b0;
    force_valid = 1'b0;
    step_valid  = 1'b0;
    #1;
    checkAllZero("midstep_reset");
    sbQueue.delete();
    mAccX = 0; mAccY = 0; mPX = 0; mPY = 0; mVX = 0; mVY = 0;
    mBusy = 0; mDropErr = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  // Scoreboard side: every result pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (result_valid) begin
      exp_t e;
      resultCount++;
      checkOutput("rv_busy_low", busy, 0);
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("res_posx", pos_x, e.px);
        checkOutput("res_posy", pos_y, e.py);
        checkOutput("res_velx", vel_x, e.vx);
        checkOutput("res_vely", vel_y, e.vy);
        checkOutput("res_latency", cycleCount - e.stepCycle, 5);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int savedCount;
    rst_in = 1'b1;
    init_valid = 0; init_x = 0; init_y = 0;
    force_valid = 0; force_x = 0; force_y = 0; step_valid = 0;
    mAccX = 0; mAccY = 0; mPX = 0; mPY = 0; mVX = 0; mVY = 0;
    mBusy = 0; mDropErr = 0;
    repeat (2) @(posedge clk_in);
    #1;
    checkAllZero("reset");
    rst_in = 1'b0;

    // Basic step: two x forces plus gravity.
    applyStimulus(1, 100, 200, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32, 0, 0);
    applyStimulus(0, 0, 0, 1, 32, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    checkOutput("t1_busy_after_step", busy, 1);
    waitDrain("t1");
    checkModel("t1");
    checkOutput("t1_velx_const", vel_x, 4);
    checkOutput("t1_posy_const", pos_y, 199);

    // Floor clamp with damped bounce.
    applyStimulus(1, 0, 5, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, -1600, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitDrain("t2");
    checkModel("t2");
    checkOutput("t2_posy_const", pos_y, 0);
    checkOutput("t2_vely_const", vel_y, 51);

    // Accumulator and velocity saturation.
    applyStimulus(1, 0, 1000, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 8388607, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitDrain("t3");
    checkModel("t3");
    checkOutput("t3_velx_const", vel_x, 32767);
    checkOutput("t3_posx_const", pos_x, 2047);

    // Force while busy is dropped and flagged; init clears the flag.
    applyStimulus(1, 100, 200, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 10, 10, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitDrain("t4");
    checkModel("t4");
    checkOutput("t4_droperr_const", drop_err, 1);
    applyStimulus(1, 1, 2, 0, 0, 0, 0);
    idle(1);
    checkModel("t4_init");

    // Step and force accepted in the result cycle.
    applyStimulus(1, 0, 500, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 160, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle(4);
    applyStimulus(0, 0, 0, 1, 0, 320, 1);
    waitDrain("t5");
    checkModel("t5");
    checkOutput("t5_vely_const", vel_y, 18);

    // Reset in the middle of a step aborts it.
    applyStimulus(1, 10, 10, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 50, 50, 1);
    idle(1);
    savedCount = resultCount;
    applyReset();
    idle(8);
    checkOutput("t6_no_result", resultCount, savedCount);
    checkModel("t6");

    // Init beats a simultaneous step.
    applyStimulus(1, 7, 7, 0, 0, 0, 1);
    idle(1);
    checkModel("t7");
    savedCount = resultCount;
    idle(6);
    checkOutput("t7_no_result", resultCount, savedCount);
    checkOutput("t7_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
